apb_master: RTL and testbench

APB requester that turns a simple valid/ready command port into APB SETUP/ACCESS transfers toward the memory-mapped slaves on the shared `apb_bus`, such as ROM and RAM. It decodes upper address bits into a one-hot `psel`, waits on `pready` with a programmable timeout, and returns read data or an error on a single-cycle response port. It sits between the CPU/DMA front end and the APB fabric.

---
 rtl/apb_master.sv | 139 +++++++++++++
 tb/tb_apb_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one APB SETUP/ACCESS transfer,
// decodes a one-hot slave select from the address, bounds the wait on pready with
// a programmable timeout and returns the result on a single-cycle response port.
module apb_master #(
    parameter int          ADDR_W  = 16,
    parameter int          DATA_W  = 16,
    parameter int          NSLV    = 4,
    parameter int          SEL_LSB = 14,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic [NSLV-1:0]   psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    // Width of the slave-index field; a single slave needs no decode at all.
    localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] cnt_reg;
    logic       accept;
    logic       done_ok;
    logic       done_err;
    logic       sel_active;

    // The command port is only open in IDLE and is closed while reset is asserted.
    assign cmd_ready  = (state_reg == IDLE) && !preset;
    assign accept     = cmd_valid && cmd_ready;
    assign penable    = (state_reg == ACCESS);
    assign sel_active = (state_reg == SETUP) || (state_reg == ACCESS);

    // One-hot slave select decoded from the held address, live only in SETUP/ACCESS.
    generate
        if (NSLV == 1) begin : g_one_slave
            assign psel = sel_active;
        end else begin : g_multi_slave
            logic [IDX_W-1:0] idx;
            assign idx = paddr[SEL_LSB +: IDX_W];
            for (genvar gi = 0; gi < NSLV; gi++) begin : g_psel
                assign psel[gi] = sel_active && (idx == IDX_W'(gi));
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and transfer completion; pready wins over a coincident timeout.
    always_comb begin
        state_next = state_reg;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    done_ok    = 1'b1;
                    state_next = IDLE;
                end else if ((TIMEOUT != 8'd0) && (cnt_reg == (TIMEOUT - 8'd1))) begin
                    done_err   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                // Unreachable encoding: recover silently without a response.
                state_next = IDLE;
            end
        endcase
    end

    // Command capture, wait-cycle counter and response registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            cnt_reg   <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_write ? cmd_wdata : '0;
            end
            if (state_reg == SETUP) begin
                cnt_reg <= 8'd0;
            end else if ((state_reg == ACCESS) && !done_ok && !done_err) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
            if (done_ok) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= 1'b0;
            end else if (done_err) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: read, waited write, timeout, pready/timeout tie,
// back-to-back commands and reset in the middle of a transfer.
module tb_apb_master;

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] paddr;
    logic        pwrite;
    logic [15:0] pwdata;
    logic [3:0]  psel;
    logic        penable;
    logic [15:0] prdata;
    logic        pready;

    int n_assert = 0;
    int n_fail   = 0;

    apb_master #(
        .ADDR_W (16),
        .DATA_W (16),
        .NSLV   (4),
        .SEL_LSB(14),
        .TIMEOUT(8'd4)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .psel     (psel),
        .penable  (penable),
        .prdata   (prdata),
        .pready   (pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0;
        cmd_wdata = 16'h0;
        prdata    = 16'h0;
        pready    = 1'b0;

        // ---- reset values ----
        step();
        step();
        check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        check("rst_psel",      32'(psel),      32'h0);
        check("rst_penable",   32'(penable),   32'h0);
        check("rst_paddr",     32'(paddr),     32'h0);
        check("rst_pwrite",    32'(pwrite),    32'h0);
        check("rst_pwdata",    32'(pwdata),    32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        check("rst_rsp_err",   32'(rsp_err),   32'h0);
        preset = 1'b0;
        #1;
        check("idle_cmd_ready", 32'(cmd_ready), 32'h1);

        // ---- read, 0 wait states, addr 4012 -> slave 1 ----
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h4012; cmd_wdata = 16'hFFFF;
        step();                                   // T+1 SETUP
        cmd_valid = 1'b0; cmd_addr = 16'h0;
        check("rd_setup_psel",    32'(psel),      32'h2);
        check("rd_setup_penable", 32'(penable),   32'h0);
        check("rd_setup_paddr",   32'(paddr),     32'h4012);
        check("rd_setup_pwdata",  32'(pwdata),    32'h0);
        check("rd_setup_ready",   32'(cmd_ready), 32'h0);
        step();                                   // T+2 ACCESS
        pready = 1'b1; prdata = 16'hBEEF;
        check("rd_acc_penable",   32'(penable),   32'h1);
        check("rd_acc_psel",      32'(psel),      32'h2);
        step();                                   // T+3 response
        pready = 1'b0; prdata = 16'h0;
        check("rd_rsp_valid",     32'(rsp_valid), 32'h1);
        check("rd_rsp_rdata",     32'(rsp_rdata), 32'hBEEF);
        check("rd_rsp_err",       32'(rsp_err),   32'h0);
        check("rd_idle_psel",     32'(psel),      32'h0);
        check("rd_idle_penable",  32'(penable),   32'h0);
        check("rd_idle_ready",    32'(cmd_ready), 32'h1);
        step();                                   // T+4
        check("rd_pulse_end",     32'(rsp_valid), 32'h0);
        check("rd_rdata_hold",    32'(rsp_rdata), 32'hBEEF);
        check("rd_paddr_hold",    32'(paddr),     32'h4012);

        // ---- timeout: read addr 0010 -> slave 0, pready stuck low ----
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010;
        step();                                   // T+1 SETUP
        cmd_valid = 1'b0;
        check("to_setup_psel",    32'(psel),      32'h1);
        step();                                   // T+2 ACCESS
        step();                                   // T+3
        step();                                   // T+4
        step();                                   // T+5 last ACCESS
        check("to_acc5_penable",  32'(penable),   32'h1);
        check("to_acc5_rsp",      32'(rsp_valid), 32'h0);
        step();                                   // T+6 abort response
        check("to_rsp_valid",     32'(rsp_valid), 32'h1);
        check("to_rsp_err",       32'(rsp_err),   32'h1);
        check("to_rsp_rdata",     32'(rsp_rdata), 32'h0);
        check("to_psel",          32'(psel),      32'h0);
        check("to_penable",       32'(penable),   32'h0);
        check("to_ready",         32'(cmd_ready), 32'h1);
        step();
        check("to_err_hold",      32'(rsp_err),   32'h1);

        // ---- pready on the 4th ACCESS cycle: pready beats timeout ----
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h8ABC;
        step();                                   // T+1 SETUP
        cmd_valid = 1'b0;
        check("tie_setup_psel",   32'(psel),      32'h4);
        step();                                   // T+2
        step();                                   // T+3
        step();                                   // T+4
        step();                                   // T+5 4th ACCESS
        pready = 1'b1; prdata = 16'h1357;
        step();                                   // T+6
        pready = 1'b0; prdata = 16'h0;
        check("tie_rsp_valid",    32'(rsp_valid), 32'h1);
        check("tie_rsp_err",      32'(rsp_err),   32'h0);
        check("tie_rsp_rdata",    32'(rsp_rdata), 32'h1357);

        // ---- write, 2 wait states, addr C004 -> slave 3 ----
        step();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'hC004; cmd_wdata = 16'h1234;
        prdata = 16'h5555;
        step();                                   // T+1 SETUP
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_wdata = 16'h0; cmd_addr = 16'h0;
        check("wr_setup_psel",    32'(psel),      32'h8);
        check("wr_setup_pwrite",  32'(pwrite),    32'h1);
        check("wr_setup_pwdata",  32'(pwdata),    32'h1234);
        step();                                   // T+2 ACCESS
        check("wr_t2_pwdata",     32'(pwdata),    32'h1234);
        step();                                   // T+3 ACCESS
        check("wr_t3_pwdata",     32'(pwdata),    32'h1234);
        check("wr_t3_rsp",        32'(rsp_valid), 32'h0);
        step();                                   // T+4 ACCESS
        pready = 1'b1;
        check("wr_t4_pwdata",     32'(pwdata),    32'h1234);
        check("wr_t4_penable",    32'(penable),   32'h1);
        check("wr_t4_paddr",      32'(paddr),     32'hC004);
        step();                                   // T+5 response
        pready = 1'b0; prdata = 16'h0;
        check("wr_rsp_valid",     32'(rsp_valid), 32'h1);
        check("wr_rsp_rdata",     32'(rsp_rdata), 32'h0);
        check("wr_rsp_err",       32'(rsp_err),   32'h0);
        check("wr_pwdata_hold",   32'(pwdata),    32'h1234);

        // ---- back-to-back reads with cmd_valid held high ----
        step();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h4000;
        pready = 1'b1; prdata = 16'h0A0A;
        check("b2b_t0_ready",     32'(cmd_ready), 32'h1);
        step();
        check("b2b_t1_ready",     32'(cmd_ready), 32'h0);
        step();
        check("b2b_t2_ready",     32'(cmd_ready), 32'h0);
        step();
        check("b2b_t3_ready",     32'(cmd_ready), 32'h1);
        check("b2b_t3_rsp",       32'(rsp_valid), 32'h1);
        step();
        check("b2b_t4_ready",     32'(cmd_ready), 32'h0);
        check("b2b_t4_psel",      32'(psel),      32'h2);
        step();
        check("b2b_t5_ready",     32'(cmd_ready), 32'h0);
        step();
        check("b2b_t6_ready",     32'(cmd_ready), 32'h1);
        check("b2b_t6_rsp",       32'(rsp_valid), 32'h1);
        check("b2b_t6_rdata",     32'(rsp_rdata), 32'h0A0A);
        cmd_valid = 1'b0;
        pready = 1'b0; prdata = 16'h0;
        step();
        check("b2b_t7_psel",      32'(psel),      32'h0);

        // ---- reset asserted during ACCESS ----
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h4002; cmd_wdata = 16'h7777;
        step();                                   // T+1 SETUP
        cmd_valid = 1'b0;
        step();                                   // T+2 ACCESS
        check("rr_acc_penable",   32'(penable),   32'h1);
        preset = 1'b1;
        #1;
        check("rr_ready_in_rst",  32'(cmd_ready), 32'h0);
        step();                                   // reset applied
        check("rr_psel",          32'(psel),      32'h0);
        check("rr_penable",       32'(penable),   32'h0);
        check("rr_paddr",         32'(paddr),     32'h0);
        check("rr_pwrite",        32'(pwrite),    32'h0);
        check("rr_pwdata",        32'(pwdata),    32'h0);
        check("rr_rsp_valid",     32'(rsp_valid), 32'h0);
        check("rr_rsp_rdata",     32'(rsp_rdata), 32'h0);
        check("rr_rsp_err",       32'(rsp_err),   32'h0);
        preset = 1'b0;
        step();
        check("rr_no_rsp",        32'(rsp_valid), 32'h0);
        check("rr_ready_after",   32'(cmd_ready), 32'h1);

        // ---- command after reset completes normally ----
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h4100; cmd_wdata = 16'hABCD;
        step();                                   // T+1 SETUP
        cmd_valid = 1'b0;
        check("pr_setup_psel",    32'(psel),      32'h2);
        check("pr_setup_pwdata",  32'(pwdata),    32'hABCD);
        step();                                   // T+2 ACCESS
        pready = 1'b1;
        step();                                   // T+3 response
        pready = 1'b0;
        check("pr_rsp_valid",     32'(rsp_valid), 32'h1);
        check("pr_rsp_err",       32'(rsp_err),   32'h0);
        check("pr_rsp_rdata",     32'(rsp_rdata), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
